// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run-control monitor.
// The tohost mailbox encoding is: bit0 set means done, value 1 means pass.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        DONE,
        TIMEOUT
    } run_state_t;

    localparam int TOHOST_DONE_BIT  = 0;
    localparam int TOHOST_PASS_CODE = 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// A synchronous clear has priority over the increment enable.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Holds the core in reset, then counts run cycles and stores and
// latches completion from a tohost mailbox store or a cycle-budget timeout.
module cpu_run_monitor
    import cpu_run_pkg::*;
#(
    parameter int              ADDR_W         = 32,
    parameter int              DATA_W         = 32,
    parameter int              CNT_W          = 32,
    parameter int unsigned     RST_CYCLES     = 4,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(32'h4000_0010),
    parameter int unsigned     TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] MemBus_Address,
    input  logic [DATA_W-1:0] MemBus_Write_Data,
    input  logic              MemWrite_origin,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-1:0] fail_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  store_count
);

    // Thresholds compared at 64 bits so a budget beyond the counter
    // range simply never fires instead of aliasing after truncation.
    localparam logic [63:0] HOLD_LAST = 64'(RST_CYCLES) - 64'd1;
    localparam logic [63:0] TO_LAST   = 64'(TIMEOUT_CYCLES) - 64'd1;
    localparam bit          TO_ON     = (TIMEOUT_CYCLES != 0);

    run_state_t       state;
    run_state_t       state_n;
    logic [CNT_W-1:0] hold_q;
    logic             is_hold;
    logic             is_run;
    logic             hold_end;
    logic             complete;
    logic             at_limit;

    assign is_hold  = (state == HOLD);
    assign is_run   = (state == RUN);
    assign hold_end = (64'(hold_q) == HOLD_LAST);
    assign at_limit = TO_ON && (64'(cycle_count) == TO_LAST);

    assign complete = is_run
                    && MemWrite_origin
                    && (MemBus_Address == TOHOST_ADDR)
                    && MemBus_Write_Data[TOHOST_DONE_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HOLD;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cpu_reset = 1'b1;
        unique case (state)
            HOLD: begin
                if (hold_end) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                cpu_reset = 1'b0;
                if (complete) begin
                    state_n = DONE;
                end else if (at_limit) begin
                    state_n = TIMEOUT;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            TIMEOUT: begin
                state_n = TIMEOUT;
            end
            default: begin
                state_n = HOLD;
            end
        endcase
    end

    // Completion takes priority over the timeout on the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            fail_code <= '0;
        end else if (complete) begin
            done      <= 1'b1;
            pass      <= (MemBus_Write_Data == DATA_W'(TOHOST_PASS_CODE));
            fail_code <= MemBus_Write_Data >> 1;
        end else if (is_run && at_limit) begin
            timeout   <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_hold (
        .clk   (clk),
        .reset (reset),
        .clr   (!is_hold),
        .en    (is_hold),
        .q     (hold_q)
    );

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (is_run),
        .q     (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_store (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (is_run && MemWrite_origin),
        .q     (store_count)
    );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized scoreboard bench for cpu_run_monitor: two configurations
// share one stimulus stream and are checked against a countdown model.
module tb_cpu_run_monitor;

    localparam logic [31:0] TOHOST = 32'h4000_0010;
    localparam int          RSTC   = 4;
    localparam int          TO_A   = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] data  = '0;

    logic        a_cr, a_dn, a_ps, a_to;
    logic [31:0] a_fc, a_cy, a_st;
    logic        b_cr, b_dn, b_ps, b_to;
    logic [31:0] b_fc;
    logic [3:0]  b_cy, b_st;

    cpu_run_monitor #(
        .CNT_W(32), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TO_A)
    ) dut_a (
        .clk(clk), .reset(reset), .cpu_reset(a_cr),
        .MemBus_Address(addr), .MemBus_Write_Data(data),
        .MemWrite_origin(we), .done(a_dn), .pass(a_ps),
        .timeout(a_to), .fail_code(a_fc),
        .cycle_count(a_cy), .store_count(a_st)
    );

    cpu_run_monitor #(
        .CNT_W(4), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset(reset), .cpu_reset(b_cr),
        .MemBus_Address(addr), .MemBus_Write_Data(data),
        .MemWrite_origin(we), .done(b_dn), .pass(b_ps),
        .timeout(b_to), .fail_code(b_fc),
        .cycle_count(b_cy), .store_count(b_st)
    );

    typedef struct {
        logic        cr, dn, ps, to;
        logic [31:0] fc, cy, st;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } pair_t;

    pair_t sb[$];
    int tests  = 0;
    int errors = 0;

    // Model: cycles of hold left, plus plain counts and flags.
    int          m_hold [2];
    logic        m_dn [2], m_ps [2], m_to [2];
    logic [31:0] m_fc [2], m_cy [2], m_st [2];
    logic [31:0] m_max [2] = '{32'hFFFF_FFFF, 32'd15};
    int          m_lim [2] = '{TO_A, 0};

    task automatic model_step(input int i, input logic r, input logic w,
                              input logic [31:0] ad, input logic [31:0] d);
        logic        fin;
        logic [31:0] old;
        if (r) begin
            m_hold[i] = RSTC;
            m_dn[i] = 0; m_ps[i] = 0; m_to[i] = 0;
            m_fc[i] = 0; m_cy[i] = 0; m_st[i] = 0;
        end else if (m_hold[i] > 0) begin
            m_hold[i] = m_hold[i] - 1;
        end else if (!m_dn[i] && !m_to[i]) begin
            fin = w && (ad == TOHOST) && d[0];
            old = m_cy[i];
            if (m_cy[i] != m_max[i]) m_cy[i] = m_cy[i] + 1;
            if (w && m_st[i] != m_max[i]) m_st[i] = m_st[i] + 1;
            if (fin) begin
                m_dn[i] = 1;
                m_ps[i] = (d == 32'd1);
                m_fc[i] = d >> 1;
            end else if (m_lim[i] != 0 && old == 32'(m_lim[i] - 1)) begin
                m_to[i] = 1;
            end
        end
    endtask

    function automatic exp_t snap(input int i);
        exp_t e;
        e.cr = (m_hold[i] > 0) || m_dn[i] || m_to[i];
        e.dn = m_dn[i];
        e.ps = m_ps[i];
        e.to = m_to[i];
        e.fc = m_fc[i];
        e.cy = m_cy[i];
        e.st = m_st[i];
        return e;
    endfunction

    task automatic step(input logic r, input logic w,
                        input logic [31:0] ad, input logic [31:0] d);
        pair_t p;
        @(negedge clk);
        reset = r; we = w; addr = ad; data = d;
        model_step(0, r, w, ad, d);
        model_step(1, r, w, ad, d);
        @(posedge clk);
        p.a = snap(0);
        p.b = snap(1);
        sb.push_back(p);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        pair_t p;
        if (sb.size() > 0) begin
            p = sb.pop_front();
            chk("a.cpu_reset",   32'(a_cr), 32'(p.a.cr));
            chk("a.done",        32'(a_dn), 32'(p.a.dn));
            chk("a.pass",        32'(a_ps), 32'(p.a.ps));
            chk("a.timeout",     32'(a_to), 32'(p.a.to));
            chk("a.fail_code",   a_fc,      p.a.fc);
            chk("a.cycle_count", a_cy,      p.a.cy);
            chk("a.store_count", a_st,      p.a.st);
            chk("b.cpu_reset",   32'(b_cr), 32'(p.b.cr));
            chk("b.done",        32'(b_dn), 32'(p.b.dn));
            chk("b.pass",        32'(b_ps), 32'(p.b.ps));
            chk("b.timeout",     32'(b_to), 32'(p.b.to));
            chk("b.fail_code",   b_fc,      p.b.fc);
            chk("b.cycle_count", 32'(b_cy), p.b.cy);
            chk("b.store_count", 32'(b_st), p.b.st);
        end
    end

    // Random traffic never forms a completion store.
    task automatic rand_bus(output logic w, output logic [31:0] ad,
                            output logic [31:0] d);
        int k;
        w  = 1'($urandom_range(0, 1));
        k  = int'($urandom_range(0, 9));
        ad = $urandom;
        d  = $urandom;
        if (ad == TOHOST) ad = ad ^ 32'h1;
        if (k == 0) begin
            ad = TOHOST;
            d  = d & ~32'h1;
        end else if (k == 1) begin
            ad = TOHOST ^ (32'h1 << $urandom_range(0, 31));
            d  = d | 32'h1;
        end
    endtask

    task automatic run_rand(input int n);
        logic        w;
        logic [31:0] ad, d;
        repeat (n) begin
            rand_bus(w, ad, d);
            step(1'b0, w, ad, d);
        end
    endtask

    task automatic run_to(input logic [31:0] target);
        logic        w;
        logic [31:0] ad, d;
        int          n;
        n = 0;
        while (m_cy[0] != target && n < 500) begin
            rand_bus(w, ad, d);
            step(1'b0, w, ad, d);
            n++;
        end
        tests++;
        if (m_cy[0] != target) begin
            errors++;
            $display("FAIL run_to: got %0d expected %0d", m_cy[0], target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, '0, '0);
        run_to(32'd20);
        step(1'b0, 1'b1, TOHOST, 32'h1);
        run_rand(5);

        repeat (2) step(1'b1, 1'b0, '0, '0);
        run_to(32'd10);
        step(1'b0, 1'b1, TOHOST, 32'h2);
        run_rand(3);
        step(1'b0, 1'b1, TOHOST, 32'hB);
        run_rand(4);

        step(1'b1, 1'b0, '0, '0);
        run_rand(RSTC + TO_A + 10);

        repeat (2) step(1'b1, 1'b0, '0, '0);
        run_to(32'd49);
        step(1'b0, 1'b1, TOHOST, 32'h1);
        run_rand(5);

        step(1'b1, 1'b0, '0, '0);
        repeat (RSTC) step(1'b0, 1'b1, 32'h200, 32'h3);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 32'h100 + 32'(i), $urandom);
        run_rand(3);

        step(1'b1, 1'b0, '0, '0);
        repeat (2) step(1'b0, 1'b1, TOHOST, 32'h1);
        step(1'b1, 1'b0, '0, '0);
        run_rand(30);
        step(1'b0, 1'b1, TOHOST, 32'h7);
        run_rand(2);

        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
